// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and constants for the data-memory load/store path.
//   size_e  : access size encodings as presented on the CPU side.
//   state_e : md_lsu sequencing states.
//   MD_MEM_WORDS : default MD depth in 32-bit words.
package mips_mem_pkg;

  localparam int unsigned MD_MEM_WORDS = 301;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RSP
  } state_e;

  // True when a request cannot be serviced: reserved size or lane misalignment.
  function automatic logic misaligned(input size_e sz, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = |lane;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for md_lsu (little-endian).
//   i_word  [31:0] : word read from MD
//   i_lane  [1:0]  : byte lane (address bits [1:0])
//   i_size         : access size
//   i_sgn          : sign-extend byte/half loads
//   i_wdata [31:0] : right-justified store data
//   o_load  [31:0] : extracted and extended load value
//   o_store [31:0] : i_word with the store lane replaced (or i_wdata for word)
module lsu_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  size_e       i_size,
  input  logic        i_sgn,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_store
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_lane)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_load = i_word;
    case (i_size)
      SZ_BYTE: o_load = {{24{i_sgn & w_byte[7]}}, w_byte};
      SZ_HALF: o_load = {{16{i_sgn & w_half[15]}}, w_half};
      default: o_load = i_word;
    endcase
  end

  always_comb begin
    o_store = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        o_store = i_word;
        case (i_lane)
          2'd0: o_store[7:0]   = i_wdata[7:0];
          2'd1: o_store[15:8]  = i_wdata[7:0];
          2'd2: o_store[23:16] = i_wdata[7:0];
          2'd3: o_store[31:24] = i_wdata[7:0];
          default: o_store = i_word;
        endcase
      end
      SZ_HALF: begin
        o_store = i_word;
        if (i_lane[1]) o_store[31:16] = i_wdata[15:0];
        else           o_store[15:0]  = i_wdata[15:0];
      end
      default: o_store = i_wdata;
    endcase
  end

endmodule

// File: rtl/md_lsu.sv
// md_lsu: load/store unit in front of the data memory MD.
//   clk, rst_n        : clock, synchronous active-low reset
//   req/ready         : request handshake (accept on req && ready at posedge)
//   we, size, sgn     : store flag, access size, sign-extend loads
//   addr, wdata       : byte address, right-justified store data
//   done, fault, rdata: completion pulse, fault flag, load result
//   AM, DM_, EW       : MD word index, write data, write enable
//   DM                : MD read data (combinational from AM)
// Sub-word stores read MD in RD, merge, then write in WR.
module md_lsu
  import mips_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MD_MEM_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  output logic        ready,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic [31:0] AM,
  output logic [31:0] DM_,
  output logic        EW,
  input  logic [31:0] DM
);

  state_e      r_state;
  logic        r_we;
  size_e       r_size;
  logic        r_sgn;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;

  size_e       w_size;
  logic        w_oob;
  logic        w_fault;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  always_comb begin
    w_size  = size_e'(size);
    w_oob   = ({2'b00, addr[31:2]} >= MEM_WORDS);
    w_fault = misaligned(w_size, addr[1:0]) | w_oob;
  end

  lsu_align u_align (
    .i_word  (DM),
    .i_lane  (r_lane),
    .i_size  (r_size),
    .i_sgn   (r_sgn),
    .i_wdata (r_wdata),
    .o_load  (w_load),
    .o_store (w_merge)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_size  <= SZ_BYTE;
      r_sgn   <= 1'b0;
      r_lane  <= '0;
      r_wdata <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
      fault   <= 1'b0;
      rdata   <= '0;
      AM      <= '0;
      DM_     <= '0;
      EW      <= 1'b0;
    end else begin
      // done/fault/EW are single-cycle pulses; each state re-asserts as needed.
      done  <= 1'b0;
      fault <= 1'b0;
      EW    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            ready   <= 1'b0;
            r_we    <= we;
            r_size  <= w_size;
            r_sgn   <= sgn;
            r_lane  <= addr[1:0];
            r_wdata <= wdata;
            AM      <= {2'b00, addr[31:2]};
            if (w_fault) begin
              r_state <= ST_RSP;
              done    <= 1'b1;
              fault   <= 1'b1;
              rdata   <= '0;
            end else if (we && w_size == SZ_WORD) begin
              // Whole-word store skips the read; write data is ready now.
              r_state <= ST_WR;
              EW      <= 1'b1;
              DM_     <= wdata;
            end else begin
              r_state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (r_we) begin
            r_state <= ST_WR;
            EW      <= 1'b1;
            DM_     <= w_merge;
          end else begin
            r_state <= ST_RSP;
            rdata   <= w_load;
            done    <= 1'b1;
          end
        end
        ST_WR: begin
          r_state <= ST_RSP;
          done    <= 1'b1;
        end
        ST_RSP: begin
          r_state <= ST_IDLE;
          ready   <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_lsu.sv
// tb_md_lsu: self-checking bench for md_lsu with a behavioural MD model.
module tb_md_lsu;

  localparam int unsigned NW = 301;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        ready;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sgn = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        done;
  logic        fault;
  logic [31:0] rdata;
  logic [31:0] AM;
  logic [31:0] DM_;
  logic        EW;
  logic [31:0] DM;

  logic [31:0] mem [0:NW-1];

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0]  done_cyc;
    logic [7:0]  ew_cnt;
    logic [7:0]  ew_cyc;
    logic [31:0] am;
    logic [31:0] dm;
    logic        flt;
    logic [31:0] rd;
  } rec_t;

  rec_t sb [$];

  md_lsu #(.MEM_WORDS(NW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .ready (ready),
    .we    (we),
    .size  (size),
    .sgn   (sgn),
    .addr  (addr),
    .wdata (wdata),
    .done  (done),
    .fault (fault),
    .rdata (rdata),
    .AM    (AM),
    .DM_   (DM_),
    .EW    (EW),
    .DM    (DM)
  );

  always #5 clk = ~clk;

  assign DM = (AM < NW) ? mem[AM[8:0]] : 32'h0;

  always @(negedge clk) begin
    if (EW === 1'b1 && AM < NW) mem[AM[8:0]] <= DM_;
  end

  function automatic rec_t mk(input int dc, input int ec, input int ecyc,
                              input logic [31:0] am, input logic [31:0] dm,
                              input logic f, input logic [31:0] rd);
    rec_t r;
    r.done_cyc = 8'(dc);
    r.ew_cnt   = 8'(ec);
    r.ew_cyc   = 8'(ecyc);
    r.am       = am;
    r.dm       = dm;
    r.flt      = f;
    r.rd       = rd;
    return r;
  endfunction

  // Drives one request and records what the DUT does up to its done pulse.
  // Called at #1 after a posedge with the DUT idle; returns at #1 after the
  // posedge following done (DUT idle again). rdata recorded only for loads
  // and faults.
  task automatic access(input logic i_we, input logic [1:0] i_sz, input logic i_sg,
                        input logic [31:0] i_ad, input logic [31:0] i_wd,
                        output rec_t o, output bit rdy_low);
    o = '0;
    rdy_low = 1'b1;
    we = i_we; size = i_sz; sgn = i_sg; addr = i_ad; wdata = i_wd; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (ready !== 1'b0) rdy_low = 1'b0;
      if (EW === 1'b1) begin
        o.ew_cnt = o.ew_cnt + 8'd1;
        o.ew_cyc = 8'(c);
        o.am     = AM;
        o.dm     = DM_;
      end
      if (done === 1'b1) begin
        o.done_cyc = 8'(c);
        o.flt      = fault;
        if (!i_we || fault === 1'b1) o.rd = rdata;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({ready, done, fault, rdata, AM, DM_, EW} !== {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset_vals: ready=%b done=%b fault=%b rdata=%h AM=%h DM_=%h EW=%b (want 1 0 0 0 0 0 0)",
               ready, done, fault, rdata, AM, DM_, EW);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word_store();
    rec_t o, e;
    bit rl;
    sb.push_back(mk(2, 1, 1, 32'd5, 32'hDEADBEEF, 1'b0, 32'h0));
    access(1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF, o, rl);
    e = sb.pop_front();
    total++;
    if (o !== e) begin bad++; $display("FAIL word_store: got %h want %h", o, e); end
    total++;
    if (mem[5] !== 32'hDEADBEEF) begin bad++; $display("FAIL word_store_mem: got %h want deadbeef", mem[5]); end
    sb.push_back(mk(2, 0, 0, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF));
    access(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, o, rl);
    e = sb.pop_front();
    total++;
    if (o !== e) begin bad++; $display("FAIL word_load_back: got %h want %h", o, e); end
  endtask

  task automatic test_byte_store();
    rec_t o, e;
    bit rl;
    mem[5] = 32'h11223344;
    sb.push_back(mk(3, 1, 2, 32'd5, 32'h1122AB44, 1'b0, 32'h0));
    access(1'b1, 2'b00, 1'b0, 32'h15, 32'h765432AB, o, rl);
    e = sb.pop_front();
    total++;
    if (o !== e) begin bad++; $display("FAIL byte_store: got %h want %h", o, e); end
    total++;
    if (rl !== 1'b1) begin bad++; $display("FAIL byte_store_busy: ready seen high while busy, want low"); end
    total++;
    if (mem[5] !== 32'h1122AB44) begin bad++; $display("FAIL byte_store_mem: got %h want 1122ab44", mem[5]); end
    // Half store into upper lane of index 6.
    mem[6] = 32'h01020304;
    sb.push_back(mk(3, 1, 2, 32'd6, 32'hBEEF0304, 1'b0, 32'h0));
    access(1'b1, 2'b01, 1'b0, 32'h1A, 32'h1234BEEF, o, rl);
    e = sb.pop_front();
    total++;
    if (o !== e) begin bad++; $display("FAIL half_store: got %h want %h", o, e); end
  endtask

  task automatic test_load_ext();
    logic [31:0] la [4] = '{32'h17, 32'h17, 32'h16, 32'h14};
    logic [1:0]  ls [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        lg [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] lr [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00000000};
    rec_t o, e;
    bit rl;
    mem[5] = 32'h80FF0000;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(mk(2, 0, 0, 32'h0, 32'h0, 1'b0, lr[i]));
      access(1'b0, ls[i], lg[i], la[i], 32'h0, o, rl);
      e = sb.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL load_ext[%0d]: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_faults();
    logic [31:0] fa [4] = '{32'h13, 32'h16, 32'h14, 32'h4B4};
    logic [1:0]  fs [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
    logic [31:0] snap4, snap5;
    rec_t o, e;
    bit rl;
    mem[4] = 32'hA5A5A5A5;
    mem[5] = 32'h5A5A5A5A;
    snap4 = mem[4];
    snap5 = mem[5];
    for (int i = 0; i < 4; i++) begin
      sb.push_back(mk(1, 0, 0, 32'h0, 32'h0, 1'b1, 32'h0));
      access(1'b1, fs[i], 1'b0, fa[i], 32'hFFFFFFFF, o, rl);
      e = sb.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL fault[%0d]: got %h want %h", i, o, e); end
    end
    total++;
    if ({mem[4], mem[5]} !== {snap4, snap5}) begin
      bad++; $display("FAIL fault_mem: got %h %h want %h %h", mem[4], mem[5], snap4, snap5);
    end
    // Last valid index loads without fault.
    mem[300] = 32'h0BADCAFE;
    sb.push_back(mk(2, 0, 0, 32'h0, 32'h0, 1'b0, 32'h0BADCAFE));
    access(1'b0, 2'b10, 1'b0, 32'h4B0, 32'h0, o, rl);
    e = sb.pop_front();
    total++;
    if (o !== e) begin bad++; $display("FAIL last_index: got %h want %h", o, e); end
  endtask

  task automatic test_reset_in_rd();
    int ew_seen = 0;
    int done_seen = 0;
    mem[6] = 32'hCAFEF00D;
    we = 1'b1; size = 2'b00; sgn = 1'b0; addr = 32'h19; wdata = 32'h55; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL rst_rd_busy: ready=%b want 0", ready); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({ready, done, fault, rdata, AM, DM_, EW} !== {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL rst_rd_vals: ready=%b done=%b fault=%b rdata=%h AM=%h DM_=%h EW=%b (want 1 0 0 0 0 0 0)",
               ready, done, fault, rdata, AM, DM_, EW);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (EW === 1'b1) ew_seen++;
      if (done === 1'b1) done_seen++;
      @(posedge clk); #1;
    end
    total++;
    if (ew_seen != 0 || done_seen != 0) begin
      bad++; $display("FAIL rst_rd_quiet: EW cycles=%0d done cycles=%0d want 0 0", ew_seen, done_seen);
    end
    total++;
    if (mem[6] !== 32'hCAFEF00D) begin bad++; $display("FAIL rst_rd_mem: got %h want cafef00d", mem[6]); end
  endtask

  task automatic test_back_to_back();
    logic [7:1] rdy_obs = '0;
    logic [7:1] dn_obs  = '0;
    rec_t e;
    mem[5] = 32'h80FF0000;
    mem[6] = 32'h13572468;
    sb.push_back(mk(0, 0, 0, 32'h0, 32'h0, 1'b0, 32'h80FF0000));
    sb.push_back(mk(0, 0, 0, 32'h0, 32'h0, 1'b0, 32'h13572468));
    we = 1'b0; size = 2'b10; sgn = 1'b0; addr = 32'h14; req = 1'b1;
    @(posedge clk); #1;
    // Changing addr while busy must only affect the second accept.
    addr = 32'h18;
    for (int c = 1; c <= 7; c++) begin
      if (c == 4) req = 1'b0;
      rdy_obs[c] = ready;
      dn_obs[c]  = done;
      if (done === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL b2b_extra_done: cycle %0d rdata=%h want no completion", c, rdata);
        end else begin
          e = sb.pop_front();
          if ({fault, rdata} !== {e.flt, e.rd}) begin
            bad++; $display("FAIL b2b_rdata: cycle %0d got %b %h want %b %h", c, fault, rdata, e.flt, e.rd);
          end
        end
      end
      @(posedge clk); #1;
    end
    total++;
    if (rdy_obs !== 7'b1100100) begin bad++; $display("FAIL b2b_ready: got %b want 1100100", rdy_obs); end
    total++;
    if (dn_obs !== 7'b0010010) begin bad++; $display("FAIL b2b_done: got %b want 0010010", dn_obs); end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL b2b_pending: got %0d outstanding want 0", sb.size()); end
    sb.delete();
  endtask

  initial begin
    for (int unsigned i = 0; i < NW; i++) mem[i] = i * 32'h01010101;
    test_reset();
    test_word_store();
    test_byte_store();
    test_load_ext();
    test_faults();
    test_reset_in_rd();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
